aes2_ct_fifo: RTL and testbench

// - Capture buffer directly downstream of the AES-192 core in the AES2 peripheral.
// - Captures each 128-bit ciphertext on the rising edge of the core's out_valid into a DEPTH-entry FIFO.
// - Presents the oldest entry to the register-bus wrapper as 32-bit words, so software can drain back-to-back results without losing any.

---
 rtl/aes2_ct_fifo.sv | 120 ++++++++++++
 tb/tb_aes2_ct_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes2_ct_fifo.sv
// Ciphertext capture FIFO behind the AES-192 core: edge-triggered capture of
// 128-bit results, drained by the register-bus wrapper one 32-bit word at a time.
module aes2_ct_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CT_WIDTH   = 128,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [CT_WIDTH-1:0]                          ct_i,
  input  logic                                         ct_valid_i,
  input  logic                                         clr_i,
  input  logic                                         lock_i,
  input  logic                                         pop_word_i,
  output logic [DATA_WIDTH-1:0]                        rd_data_o,
  output logic                                         rd_valid_o,
  output logic [$clog2(CT_WIDTH/DATA_WIDTH)-1:0]       word_idx_o,
  output logic [$clog2(DEPTH):0]                       count_o,
  output logic                                         empty_o,
  output logic                                         full_o,
  output logic                                         overflow_o
);

  localparam int unsigned WPE = CT_WIDTH / DATA_WIDTH;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned IW  = $clog2(WPE);
  localparam int unsigned CW  = PW + 1;

  logic [CT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]       word_idx_q, word_idx_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                ct_valid_q;

  logic push, pop_acc, free_entry, wr_en, drop, is_full, is_empty, rd_valid;

  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CW'(DEPTH));
  assign rd_valid   = ~is_empty & ~lock_i;
  assign push       = ct_valid_i & ~ct_valid_q;
  assign pop_acc    = pop_word_i & rd_valid;
  assign free_entry = pop_acc & (word_idx_q == IW'(WPE - 1));
  // A full FIFO still accepts a capture when the same cycle frees the head entry.
  assign wr_en      = push & ~clr_i & (~is_full | free_entry);
  assign drop       = push & ~clr_i & is_full & ~free_entry;

  // Next-state for pointers, word index, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      word_idx_d = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_acc) begin
        if (free_entry) begin
          word_idx_d = '0;
          rd_ptr_d   = rd_ptr_q + PW'(1);
        end else begin
          word_idx_d = word_idx_q + IW'(1);
        end
      end
      count_d = count_q + CW'(wr_en) - CW'(free_entry);
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ct_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ct_valid_q <= ct_valid_i;
    end
  end

  // Storage needs no reset: it is only observable through rd_valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= ct_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_valid) begin
      rd_data_o = mem_q[rd_ptr_q][32'(word_idx_q) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_valid_o = rd_valid;
  assign word_idx_o = word_idx_q;
  assign count_o    = count_q;
  assign empty_o    = is_empty;
  assign full_o     = is_full;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_aes2_ct_fifo.sv
// Bench for aes2_ct_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_aes2_ct_fifo;

  localparam int DEPTH = 4;
  localparam int WPE   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ct;
  logic         cv, clr, lock, pop;
  logic [31:0]  rd_data;
  logic         rd_valid, empty, full, ovf;
  logic [1:0]   widx;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  aes2_ct_fifo #(.DEPTH(DEPTH), .CT_WIDTH(128), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .ct_i(ct), .ct_valid_i(cv), .clr_i(clr),
    .lock_i(lock), .pop_word_i(pop), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .word_idx_o(widx), .count_o(count), .empty_o(empty), .full_o(full),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of whole ciphertexts plus a word cursor into the head.
  logic [127:0] mq[$];
  int           m_widx = 0;
  bit           m_ovf  = 0;
  bit           m_prev = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_widx = 0;
      m_ovf  = 0;
      m_prev = 0;
    end else begin
      bit rising, can_read;
      rising   = cv && !m_prev;
      can_read = (mq.size() > 0) && !lock;
      if (clr) begin
        mq.delete();
        m_widx = 0;
        m_ovf  = 0;
      end else begin
        if (pop && can_read) begin
          if (m_widx == WPE - 1) begin
            void'(mq.pop_front());
            m_widx = 0;
          end else begin
            m_widx++;
          end
        end
        if (rising) begin
          if (mq.size() < DEPTH) mq.push_back(ct);
          else m_ovf = 1;
        end
      end
      m_prev = cv;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [127:0] head;
    logic [31:0]  exp_data;
    bit           exp_valid;
    exp_valid = (mq.size() > 0) && !lock;
    exp_data  = '0;
    if (exp_valid) begin
      head     = mq[0];
      exp_data = head[m_widx*32 +: 32];
    end
    chk("m_rd_data",  rd_data, exp_data);
    chk("m_rd_valid", rd_valid, exp_valid);
    chk("m_count",    count, mq.size());
    chk("m_empty",    empty, mq.size() == 0);
    chk("m_full",     full, mq.size() == DEPTH);
    chk("m_overflow", ovf, m_ovf);
    chk("m_word_idx", widx, m_widx);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [127:0] d);
    ct = d; cv = 1'b1;
    step();
    cv = 1'b0;
    step();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  logic [127:0] dv [5];
  logic [127:0] nv;

  initial begin
    dv[0] = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
    dv[1] = 128'hB1B1B1B3_B1B1B1B2_B1B1B1B1_B1B1B1B0;
    dv[2] = 128'hC2C2C2C3_C2C2C2C2_C2C2C2C1_C2C2C2C0;
    dv[3] = 128'hD3D3D3D3_D3D3D3D2_D3D3D3D1_D3D3D3D0;
    dv[4] = 128'hE4E4E4E3_E4E4E4E2_E4E4E4E1_E4E4E4E0;
    nv    = 128'h5555AAA3_5555AAA2_5555AAA1_5555AAA0;

    rst = 1'b1; ct = '0; cv = 1'b0; clr = 1'b0; lock = 1'b0; pop = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 32'h0);
    chk("rst_widx", widx, 2'd0);
    step();
    rst = 1'b0;
    step();

    // Level held high for 10 cycles captures once.
    ct = 128'h00112233_44556677_8899AABB_CCDDEEFF; cv = 1'b1;
    step();
    @(negedge clk);
    chk("cap_count", count, 3'd1);
    chk("cap_data", rd_data, 32'hCCDDEEFF);
    chk("cap_widx", widx, 2'd0);
    repeat (9) step();
    @(negedge clk);
    chk("hold_count", count, 3'd1);
    step();
    cv = 1'b0;
    step();

    // Word order within one entry.
    begin
      logic [31:0] words [4];
      words[0] = 32'hCCDDEEFF; words[1] = 32'h8899AABB;
      words[2] = 32'h44556677; words[3] = 32'h00112233;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("word_seq", rd_data, words[i]);
        step();
        pop_one();
      end
    end
    @(negedge clk);
    chk("drain_empty", empty, 1'b1);
    chk("drain_data", rd_data, 32'h0);
    step();

    // Five pushes into four entries: fifth dropped, overflow sticks.
    for (int i = 0; i < 5; i++) push_one(dv[i]);
    @(negedge clk);
    chk("ovf_full", full, 1'b1);
    chk("ovf_count", count, 3'd4);
    chk("ovf_flag", ovf, 1'b1);
    step();
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      chk("ovf_order", rd_data, dv[e][31:0]);
      step();
      for (int w = 0; w < 4; w++) pop_one();
    end
    @(negedge clk);
    chk("ovf_lost", empty, 1'b1);
    step();

    // Push coincident with the freeing pop on a full FIFO.
    clr = 1'b1; step(); clr = 1'b0;
    @(negedge clk);
    chk("clr_ovf", ovf, 1'b0);
    step();
    for (int i = 0; i < 4; i++) push_one(dv[i]);
    for (int w = 0; w < 3; w++) pop_one();
    ct = nv; cv = 1'b1; pop = 1'b1;
    step();
    cv = 1'b0; pop = 1'b0;
    @(negedge clk);
    chk("swap_count", count, 3'd4);
    chk("swap_ovf", ovf, 1'b0);
    chk("swap_head", rd_data, dv[1][31:0]);
    step();
    for (int w = 0; w < 12; w++) pop_one();
    @(negedge clk);
    chk("swap_last", rd_data, 32'h5555AAA0);
    chk("swap_cnt1", count, 3'd1);
    step();

    // Lock masks readout and pops but not capture.
    clr = 1'b1; step(); clr = 1'b0;
    push_one(dv[2]);
    push_one(dv[3]);
    lock = 1'b1;
    step();
    @(negedge clk);
    chk("lock_data", rd_data, 32'h0);
    chk("lock_valid", rd_valid, 1'b0);
    step();
    pop_one();
    @(negedge clk);
    chk("lock_widx", widx, 2'd0);
    step();
    push_one(dv[4]);
    @(negedge clk);
    chk("lock_count", count, 3'd3);
    step();
    lock = 1'b0;
    @(negedge clk);
    chk("unlock_data", rd_data, dv[2][31:0]);
    step();

    // Clear together with a push, level held afterwards: no stale push.
    clr = 1'b1; ct = nv; cv = 1'b1;
    step();
    clr = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("clrpush_count", count, 3'd0);
    chk("clrpush_empty", empty, 1'b1);
    chk("clrpush_ovf", ovf, 1'b0);
    step();
    cv = 1'b0;
    step();

    // Reset mid-drain at word 2.
    push_one(dv[0]);
    push_one(dv[1]);
    pop_one(); pop_one();
    @(negedge clk);
    chk("pre_rst_widx", widx, 2'd2);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_count", count, 3'd0);
    chk("rst_mid_empty", empty, 1'b1);
    chk("rst_mid_ovf", ovf, 1'b0);
    chk("rst_mid_widx", widx, 2'd0);
    step();
    rst = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      ct   = {$urandom, $urandom, $urandom, $urandom};
      cv   = ($urandom_range(0, 99) < 45) ? ~cv : cv;
      pop  = ($urandom_range(0, 99) < 40);
      lock = ($urandom_range(0, 99) < 10);
      clr  = ($urandom_range(0, 199) < 3);
      rst  = ($urandom_range(0, 499) < 2);
      step();
    end
    rst = 1'b0; clr = 1'b0; pop = 1'b0; cv = 1'b0; lock = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
